// File: rtl/system_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : system_pkg                                                 |
// | Purpose : Shared widths, ALU opcodes and branch condition codes.     |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
package system_pkg;

  localparam int c_data_width    = 32;
  localparam int c_addr_width    = 9;
  localparam int c_reg_count     = 16;
  localparam int c_reg_sel_width = 4;

  localparam logic [4:0] c_op_add     = 5'b00011;
  localparam logic [4:0] c_op_add_alt = 5'b01100;
  localparam logic [4:0] c_op_sub     = 5'b00100;
  localparam logic [4:0] c_op_and     = 5'b00101;
  localparam logic [4:0] c_op_and_alt = 5'b01101;
  localparam logic [4:0] c_op_or      = 5'b00110;
  localparam logic [4:0] c_op_or_alt  = 5'b01110;
  localparam logic [4:0] c_op_shr     = 5'b00111;
  localparam logic [4:0] c_op_shra    = 5'b01000;
  localparam logic [4:0] c_op_shl     = 5'b01001;
  localparam logic [4:0] c_op_ror     = 5'b01010;
  localparam logic [4:0] c_op_rol     = 5'b01011;
  localparam logic [4:0] c_op_mul     = 5'b01111;
  localparam logic [4:0] c_op_div     = 5'b10000;
  localparam logic [4:0] c_op_neg     = 5'b10001;
  localparam logic [4:0] c_op_not     = 5'b10010;

  typedef enum logic [1:0] {
    c_cond_zero    = 2'b00,
    c_cond_nonzero = 2'b01,
    c_cond_pos     = 2'b10,
    c_cond_neg     = 2'b11
  } cond_e;

  function automatic logic cond_met(input logic [1:0] c2, input logic is_zero,
                                    input logic is_neg);
    cond_met = 1'b0;
    case (cond_e'(c2))
      c_cond_zero:    cond_met = is_zero;
      c_cond_nonzero: cond_met = !is_zero;
      c_cond_pos:     cond_met = !is_neg;
      c_cond_neg:     cond_met = is_neg;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/system_alu.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : system_alu                                                 |
// | Purpose : Combinational ALU, A=Y, B=bus, 64-bit Z result.            |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module system_alu
  import system_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width
) (
  input  logic [DATA_WIDTH-1:0]   i_a,
  input  logic [DATA_WIDTH-1:0]   i_b,
  input  logic [4:0]              i_opcode,
  input  logic                    i_inc_pc,
  output logic [2*DATA_WIDTH-1:0] o_z
);

  localparam int c_sh_w = $clog2(DATA_WIDTH);

  logic [c_sh_w-1:0]              w_sh;
  logic [c_sh_w-1:0]              w_sh_inv;
  logic signed [DATA_WIDTH-1:0]   w_sa;
  logic signed [DATA_WIDTH-1:0]   w_sb;
  logic signed [DATA_WIDTH-1:0]   w_quo;
  logic signed [DATA_WIDTH-1:0]   w_rem;
  logic signed [2*DATA_WIDTH-1:0] w_ext_a;
  logic signed [2*DATA_WIDTH-1:0] w_ext_b;
  logic signed [2*DATA_WIDTH-1:0] w_prod;

  assign w_sh     = i_b[c_sh_w-1:0];
  // Rotate partner shift is (-n mod W); for n=0 both halves are i_a and OR to i_a.
  assign w_sh_inv = -w_sh;
  assign w_sa     = i_a;
  assign w_sb     = i_b;
  assign w_ext_a  = {{DATA_WIDTH{i_a[DATA_WIDTH-1]}}, i_a};
  assign w_ext_b  = {{DATA_WIDTH{i_b[DATA_WIDTH-1]}}, i_b};
  assign w_prod   = w_ext_a * w_ext_b;
  assign w_quo    = w_sa / w_sb;
  assign w_rem    = w_sa % w_sb;

  always_comb begin
    o_z = '0;
    if (i_inc_pc) begin
      o_z[DATA_WIDTH-1:0] = i_b + DATA_WIDTH'(1);
    end else begin
      case (i_opcode)
        c_op_add, c_op_add_alt: o_z[DATA_WIDTH-1:0] = i_a + i_b;
        c_op_sub:               o_z[DATA_WIDTH-1:0] = i_a - i_b;
        c_op_and, c_op_and_alt: o_z[DATA_WIDTH-1:0] = i_a & i_b;
        c_op_or, c_op_or_alt:   o_z[DATA_WIDTH-1:0] = i_a | i_b;
        c_op_shr:               o_z[DATA_WIDTH-1:0] = i_a >> w_sh;
        c_op_shra:              o_z[DATA_WIDTH-1:0] = w_sa >>> w_sh;
        c_op_shl:               o_z[DATA_WIDTH-1:0] = i_a << w_sh;
        c_op_ror:               o_z[DATA_WIDTH-1:0] = (i_a >> w_sh) | (i_a << w_sh_inv);
        c_op_rol:               o_z[DATA_WIDTH-1:0] = (i_a << w_sh) | (i_a >> w_sh_inv);
        c_op_mul:               o_z = w_prod;
        c_op_div: begin
          if (i_b != '0) o_z = {w_rem, w_quo};
        end
        c_op_neg:               o_z[DATA_WIDTH-1:0] = -i_b;
        c_op_not:               o_z[DATA_WIDTH-1:0] = ~i_b;
        default:                o_z = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/system.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : system                                                     |
// | Purpose : Single-bus 32-bit datapath with register file, ALU, I/O    |
// |           ports and a 512x32 single-cycle memory.                    |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module system
  import system_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width,
  parameter int ADDR_WIDTH = c_addr_width
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] inport_data,
  input  logic                  inport_data_ready,
  output logic [DATA_WIDTH-1:0] outport_data,
  input  logic                  outport_in,
  input  logic                  HIout,
  input  logic                  LOout,
  input  logic                  Zhi_out,
  input  logic                  Zlo_out,
  input  logic                  PCout,
  input  logic                  MDRout,
  input  logic                  Inport_out,
  input  logic                  Cout,
  input  logic                  MARin,
  input  logic                  Zin,
  input  logic                  PCin,
  input  logic                  MDRin,
  input  logic                  IRin,
  input  logic                  Yin,
  input  logic                  HIin,
  input  logic                  LOin,
  input  logic                  CONin,
  input  logic [4:0]            opcode,
  input  logic                  IncPC,
  input  logic                  Gra,
  input  logic                  Grb,
  input  logic                  Grc,
  input  logic                  Rin,
  input  logic                  Rout,
  input  logic                  BAout,
  output logic                  con_ff_bit,
  input  logic                  Mem_Read,
  input  logic                  Mem_Write,
  input  logic                  Mem_enable512x32,
  output logic [DATA_WIDTH-1:0] Mem_to_datapath_out,
  output logic [DATA_WIDTH-1:0] Mem_data_to_chip_out,
  output logic [ADDR_WIDTH-1:0] MAR_address_out,
  output logic                  memory_done,
  input  logic                  mem_overide,
  input  logic [ADDR_WIDTH-1:0] overide_address,
  input  logic [DATA_WIDTH-1:0] overide_data_in
);

  logic [DATA_WIDTH-1:0]   r_pc, r_mdr, r_y, r_hi, r_lo, r_inport, r_outport;
  logic [2*DATA_WIDTH-1:0] r_z;
  // Only the register/constant fields are decoded; the opcode arrives on its own port.
  logic [26:0]             r_ir;
  logic [ADDR_WIDTH-1:0]   r_mar;
  logic                    r_con;
  logic [DATA_WIDTH-1:0]   r_regs [c_reg_count];
  logic [DATA_WIDTH-1:0]   r_mem  [2**ADDR_WIDTH];

  logic [DATA_WIDTH-1:0]      w_bus, w_reg_out, w_c, w_mem_rd, w_mem_wr_data;
  logic [2*DATA_WIDTH-1:0]    w_alu_z;
  logic [c_reg_sel_width-1:0] w_sel;
  logic [ADDR_WIDTH-1:0]      w_mem_addr;
  logic                       w_mem_we;

  always_comb begin
    w_sel = '0;
    if (Gra)      w_sel = r_ir[26:23];
    else if (Grb) w_sel = r_ir[22:19];
    else if (Grc) w_sel = r_ir[18:15];
  end

  assign w_reg_out = (BAout && w_sel == '0) ? '0 : r_regs[w_sel];
  assign w_c       = {{(DATA_WIDTH-19){r_ir[18]}}, r_ir[18:0]};

  always_comb begin
    w_bus = '0;
    if (Zlo_out)            w_bus = r_z[DATA_WIDTH-1:0];
    else if (Zhi_out)       w_bus = r_z[2*DATA_WIDTH-1:DATA_WIDTH];
    else if (HIout)         w_bus = r_hi;
    else if (LOout)         w_bus = r_lo;
    else if (PCout)         w_bus = r_pc;
    else if (MDRout)        w_bus = r_mdr;
    else if (Inport_out)    w_bus = r_inport;
    else if (Cout)          w_bus = w_c;
    else if (Rout || BAout) w_bus = w_reg_out;
  end

  system_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .i_a      (r_y),
    .i_b      (w_bus),
    .i_opcode (opcode),
    .i_inc_pc (IncPC),
    .o_z      (w_alu_z)
  );

  assign w_mem_addr    = mem_overide ? overide_address : r_mar;
  assign w_mem_rd      = (Mem_enable512x32 && Mem_Read) ? r_mem[w_mem_addr] : '0;
  assign w_mem_wr_data = mem_overide ? overide_data_in : r_mdr;
  // Qualified by clear so an edge seen while reset is held never commits a write.
  assign w_mem_we      = clear && Mem_enable512x32 && (mem_overide || Mem_Write);

  always_ff @(posedge Clock) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wr_data;
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      r_pc      <= '0;
      r_ir      <= '0;
      r_mar     <= '0;
      r_mdr     <= '0;
      r_y       <= '0;
      r_z       <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_con     <= 1'b0;
      r_inport  <= '0;
      r_outport <= '0;
      for (int i = 0; i < c_reg_count; i++) r_regs[i] <= '0;
    end else begin
      if (PCin)              r_pc      <= w_bus;
      if (IRin)              r_ir      <= w_bus[26:0];
      if (MARin)             r_mar     <= w_bus[ADDR_WIDTH-1:0];
      if (MDRin)             r_mdr     <= Mem_Read ? w_mem_rd : w_bus;
      if (Yin)               r_y       <= w_bus;
      if (Zin)               r_z       <= w_alu_z;
      if (HIin)              r_hi      <= w_bus;
      if (LOin)              r_lo      <= w_bus;
      if (CONin)             r_con     <= cond_met(r_ir[20:19], w_bus == '0, w_bus[DATA_WIDTH-1]);
      if (inport_data_ready) r_inport  <= inport_data;
      if (outport_in)        r_outport <= w_bus;
      if (Rin)               r_regs[w_sel] <= w_bus;
    end
  end

  assign outport_data         = r_outport;
  assign con_ff_bit           = r_con;
  assign Mem_to_datapath_out  = w_mem_rd;
  assign Mem_data_to_chip_out = r_mdr;
  assign MAR_address_out      = r_mar;
  assign memory_done          = Mem_enable512x32;

endmodule
`default_nettype wire

// File: tb/tb_system.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_system                                                  |
// | Purpose : Scoreboard bench for the system datapath.                  |
// | Rev     : 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_system;

  logic        Clock = 1'b0;
  logic        clear;
  logic [31:0] inport_data, outport_data;
  logic        inport_data_ready, outport_in;
  logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin;
  logic [4:0]  opcode;
  logic        IncPC, Gra, Grb, Grc, Rin, Rout, BAout, con_ff_bit;
  logic        Mem_Read, Mem_Write, Mem_enable512x32, memory_done, mem_overide;
  logic [31:0] Mem_to_datapath_out, Mem_data_to_chip_out, overide_data_in;
  logic [8:0]  MAR_address_out, overide_address;

  system dut (
    .Clock(Clock), .clear(clear), .inport_data(inport_data),
    .inport_data_ready(inport_data_ready), .outport_data(outport_data),
    .outport_in(outport_in), .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out),
    .Zlo_out(Zlo_out), .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out),
    .Cout(Cout), .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .CONin(CONin), .opcode(opcode),
    .IncPC(IncPC), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .BAout(BAout), .con_ff_bit(con_ff_bit), .Mem_Read(Mem_Read),
    .Mem_Write(Mem_Write), .Mem_enable512x32(Mem_enable512x32),
    .Mem_to_datapath_out(Mem_to_datapath_out),
    .Mem_data_to_chip_out(Mem_data_to_chip_out),
    .MAR_address_out(MAR_address_out), .memory_done(memory_done),
    .mem_overide(mem_overide), .overide_address(overide_address),
    .overide_data_in(overide_data_in)
  );

  always #5 Clock = ~Clock;

  localparam int c_src_pc = 0, c_src_zlo = 1, c_src_zhi = 2, c_src_hi = 3, c_src_lo = 4;
  localparam int c_src_ra = 5, c_src_rb = 6, c_src_rb_ba = 7, c_src_prio = 8;

  int          n_vec = 0;
  int          n_err = 0;
  string       sb_tag[$];
  logic [31:0] sb_val[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] val);
    sb_tag.push_back(tag);
    sb_val.push_back(val);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    if (sb_val.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_empty: got %h expected a queued value", obs);
    end else begin
      chk(sb_tag.pop_front(), obs, sb_val.pop_front());
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    {inport_data_ready, outport_in, HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout,
     Inport_out, Cout, MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin} = '0;
    {IncPC, Gra, Grb, Grc, Rin, Rout, BAout, Mem_Read, Mem_Write, Mem_enable512x32,
     mem_overide} = '0;
    opcode = 5'd0;
  endtask

  task automatic observe(input int src, input logic [31:0] exp, input string tag);
    sb_push(tag, exp);
    idle();
    case (src)
      c_src_pc:    PCout = 1;
      c_src_zlo:   Zlo_out = 1;
      c_src_zhi:   Zhi_out = 1;
      c_src_hi:    HIout = 1;
      c_src_lo:    LOout = 1;
      c_src_ra:    begin Gra = 1; Rout = 1; end
      c_src_rb:    begin Grb = 1; Rout = 1; end
      c_src_rb_ba: begin Grb = 1; BAout = 1; end
      default:     begin HIout = 1; LOout = 1; PCout = 1; Inport_out = 1; end
    endcase
    outport_in = 1;
    tick();
    idle();
    sb_check(outport_data);
  endtask

  task automatic load_in(input logic [31:0] v);
    idle();
    inport_data = v;
    inport_data_ready = 1;
    tick();
    idle();
    Inport_out = 1;
  endtask

  task automatic fetch();
    idle(); PCout = 1; IncPC = 1; MARin = 1; Zin = 1; tick();
    idle(); Zlo_out = 1; PCin = 1; MDRin = 1; Mem_Read = 1; Mem_enable512x32 = 1; tick();
    idle(); MDRout = 1; IRin = 1; tick();
    idle();
  endtask

  task automatic branch(input logic [31:0] pc_now, input logic exp_con, input string tag);
    idle(); Gra = 1; Rout = 1; CONin = 1; tick(); idle();
    chk({tag, "_con"}, {31'd0, con_ff_bit}, {31'd0, exp_con});
    PCout = 1; Yin = 1; tick(); idle();
    Cout = 1; Zin = 1; opcode = 5'b00011; tick(); idle();
    observe(c_src_zlo, pc_now + 32'd1, {tag, "_target"});
    if (con_ff_bit) begin
      Zlo_out = 1; PCin = 1; tick(); idle();
    end
    observe(c_src_pc, exp_con ? pc_now + 32'd1 : pc_now, {tag, "_pc"});
  endtask

  function automatic logic [63:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op, input logic inc);
    longint      sa, sb;
    logic [31:0] r;
    int          n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    r  = 32'd0;
    if (inc) return {32'd0, b + 32'd1};
    case (op)
      5'b00011, 5'b01100: r = a + b;
      5'b00100:           r = a - b;
      5'b00101, 5'b01101: r = a & b;
      5'b00110, 5'b01110: r = a | b;
      5'b00111:           r = a >> n;
      5'b01000:           r = 32'(sa >>> n);
      5'b01001:           r = a << n;
      5'b01010:           for (int i = 0; i < 32; i++) r[i] = a[(i + n) % 32];
      5'b01011:           for (int i = 0; i < 32; i++) r[(i + n) % 32] = a[i];
      5'b01111:           return 64'(sa * sb);
      5'b10000:           if (b == 32'd0) return 64'd0;
                          else return {32'(sa % sb), 32'(sa / sb)};
      5'b10001:           r = 32'd0 - b;
      5'b10010:           r = ~b;
      default:            r = 32'd0;
    endcase
    return {32'd0, r};
  endfunction

  task automatic alu_vec(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                         input logic inc, input logic [63:0] exp, input string tag);
    load_in(a); Yin = 1; tick();
    load_in(b); Zin = 1; opcode = op; IncPC = inc; tick(); idle();
    observe(c_src_zlo, exp[31:0], {tag, "_zlo"});
    observe(c_src_zhi, exp[63:32], {tag, "_zhi"});
  endtask

  logic [8:0]  ld_addr [5] = '{9'd0, 9'd1, 9'd3, 9'd4, 9'd5};
  logic [31:0] ld_data [5] = '{32'h0A800000, 32'h9A800001, 32'h9A880001,
                               32'h9A900001, 32'h9A980001};
  logic [4:0]  op_pool [16] = '{5'b00011, 5'b01100, 5'b00100, 5'b00101, 5'b00110,
                                5'b00111, 5'b01000, 5'b01001, 5'b01010, 5'b01011,
                                5'b01111, 5'b10000, 5'b10001, 5'b10010, 5'b11111,
                                5'b01110};

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb;
    logic [4:0]  rop;
    clear = 1'b0;
    idle();
    inport_data = '0;
    overide_address = '0;
    overide_data_in = '0;
    repeat (2) tick();
    chk("rst_outport", outport_data, 32'd0);
    chk("rst_con", {31'd0, con_ff_bit}, 32'd0);
    chk("rst_mar", {23'd0, MAR_address_out}, 32'd0);
    chk("rst_mdr", Mem_data_to_chip_out, 32'd0);
    chk("rst_memrd", Mem_to_datapath_out, 32'd0);
    chk("rst_done", {31'd0, memory_done}, 32'd0);
    clear = 1'b1;

    for (int i = 0; i < 5; i++) begin
      idle();
      mem_overide = 1; Mem_enable512x32 = 1;
      overide_address = ld_addr[i]; overide_data_in = ld_data[i];
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      idle();
      mem_overide = 1; Mem_enable512x32 = 1; Mem_Read = 1;
      overide_address = ld_addr[i]; overide_data_in = ld_data[i];
      sb_push($sformatf("mem_rb%0d", ld_addr[i]), ld_data[i]);
      #1;
      sb_check(Mem_to_datapath_out);
      if (i == 0) chk("mem_done", {31'd0, memory_done}, 32'd1);
      tick();
    end
    idle();

    fetch();
    chk("fetch0_mar", {23'd0, MAR_address_out}, 32'd0);
    chk("fetch0_mdr", Mem_data_to_chip_out, 32'h0A800000);
    observe(c_src_pc, 32'd1, "fetch0_pc");

    load_in(32'hDEADBEEF); Gra = 1; Rin = 1; tick();
    observe(c_src_ra, 32'hDEADBEEF, "r5_pre");
    load_in(32'hDEADBEEF); Grb = 1; Rin = 1; tick();
    observe(c_src_rb, 32'hDEADBEEF, "r0_rout");
    observe(c_src_rb_ba, 32'd0, "r0_baout");
    idle(); Grb = 1; BAout = 1; Yin = 1; tick();
    idle(); Cout = 1; Zin = 1; opcode = 5'b00011; tick();
    idle(); Zlo_out = 1; Gra = 1; Rin = 1; tick();
    observe(c_src_ra, 32'd0, "ldi_r5");

    fetch();
    observe(c_src_pc, 32'd2, "fetch1_pc");
    branch(32'd2, 1'b1, "brzr");
    fetch();
    branch(32'd4, 1'b0, "brnz");
    fetch();
    branch(32'd5, 1'b1, "brpl");
    load_in(32'd5); PCin = 1; tick();
    fetch();
    branch(32'd6, 1'b0, "brmi");

    alu_vec(32'd7, 32'hFFFFFFFD, 5'b01111, 1'b0, 64'hFFFFFFFF_FFFFFFEB, "mul_7xm3");
    alu_vec(32'hFFFFFFF9, 32'd2, 5'b10000, 1'b0, 64'hFFFFFFFF_FFFFFFFD, "div_m7d2");
    alu_vec(32'd1234, 32'd0, 5'b10000, 1'b0, 64'd0, "div_by0");
    alu_vec(32'h80000001, 32'd4, 5'b01010, 1'b0, 64'h00000000_18000000, "ror4");
    alu_vec(32'h80000001, 32'd0, 5'b01011, 1'b0, 64'h00000000_80000001, "rol0");
    alu_vec(32'h80000000, 32'd31, 5'b01000, 1'b0, 64'h00000000_FFFFFFFF, "shra31");
    alu_vec(32'd55, 32'hFFFFFFFF, 5'b00011, 1'b1, 64'd0, "incpc_wrap");
    alu_vec(32'd3, 32'd10, 5'b00100, 1'b0, 64'h00000000_FFFFFFF9, "sub");
    alu_vec(32'hFFFF0000, 32'h0000FFFF, 5'b11111, 1'b0, 64'd0, "op_invalid");
    for (int i = 0; i < 12; i++) begin
      ra  = $urandom();
      rb  = $urandom();
      rop = op_pool[$urandom_range(0, 15)];
      if (rop == 5'b10000 && ra == 32'h80000000) ra = 32'h7FFFFFFF;
      alu_vec(ra, rb, rop, 1'b0, alu_model(ra, rb, rop, 1'b0), $sformatf("rnd%0d", i));
    end

    load_in(32'h11112222); HIin = 1; tick();
    load_in(32'h33334444); LOin = 1; tick();
    observe(c_src_hi, 32'h11112222, "hi");
    observe(c_src_lo, 32'h33334444, "lo");
    observe(c_src_prio, 32'h11112222, "bus_prio");

    load_in(32'h20); MARin = 1; tick();
    load_in(32'h12345678); MDRin = 1; tick();
    idle(); Mem_Write = 1; Mem_enable512x32 = 1; tick();
    idle(); Mem_Read = 1; Mem_enable512x32 = 1; #1;
    chk("mdr_wr_mar", {23'd0, MAR_address_out}, 32'h20);
    chk("mdr_wr_rd", Mem_to_datapath_out, 32'h12345678);
    tick();

    load_in(32'h80000000); CONin = 1; tick(); idle();
    chk("pre_rst_con", {31'd0, con_ff_bit}, 32'd1);
    PCout = 1; IncPC = 1; MARin = 1; Zin = 1; Mem_Write = 1; Mem_enable512x32 = 1;
    #3;
    clear = 1'b0;
    #1;
    chk("midrst_con", {31'd0, con_ff_bit}, 32'd0);
    chk("midrst_mar", {23'd0, MAR_address_out}, 32'd0);
    chk("midrst_mdr", Mem_data_to_chip_out, 32'd0);
    chk("midrst_outport", outport_data, 32'd0);
    tick();
    clear = 1'b1;
    idle(); Mem_Read = 1; Mem_enable512x32 = 1; #1;
    chk("midrst_nowrite", Mem_to_datapath_out, 32'h0A800000);
    observe(c_src_pc, 32'd0, "midrst_pc");

    if (sb_val.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_left: got %0d entries expected 0", sb_val.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/system.md
SYSTEM -- requirements
Module: system

Interface
REQ-001 Parameters: DATA_WIDTH=32 (datapath/word width); ADDR_WIDTH=9 (memory address width, 512 words).
REQ-002 Clock  in  1  single rising-edge clock for all state.
REQ-003 clear  in  1  asynchronous active-low reset.
REQ-004 inport_data  in  32  external input-port data; inport_data_ready  in  1  load inport register.
REQ-005 outport_data  out  32  output-port register value; outport_in  in  1  load outport from bus.
REQ-006 HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout  in  1 each  bus-drive selects.
REQ-007 MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, CONin  in  1 each  register load enables.
REQ-008 opcode  in  5  ALU operation; IncPC  in  1  ALU computes bus+1.
REQ-009 Gra, Grb, Grc, Rin, Rout, BAout  in  1 each  register-file select/enable.
REQ-010 con_ff_bit  out  1  CON flip-flop.
REQ-011 Mem_Read, Mem_Write, Mem_enable512x32  in  1 each  memory read, write, enable.
REQ-012 Mem_to_datapath_out  out  32  memory read data; Mem_data_to_chip_out  out  32  memory write data (MDR); MAR_address_out  out  9  MAR[8:0]; memory_done  out  1  access complete.
REQ-013 mem_overide  in  1  test-load mode; overide_address  in  9; overide_data_in  in  32.

Function
REQ-014 32-bit bus SHALL be driven by the single asserted out-select; priority if several: Zlo, Zhi, HI, LO, PC, MDR, Inport, C, register; none asserted -> 0.
REQ-015 Register file R0-R15; Ra=IR[26:23], Rb=IR[22:19], Rc=IR[18:15]; Gra/Grb/Grc select; Rin writes bus at edge; Rout drives selected reg; BAout drives selected reg except R0 reads 0.
REQ-016 C = sign-extended IR[18:0]; Cout drives C.
REQ-017 ALU A=Y, B=bus; IncPC overrides: Z=B+1. Opcodes: 00011/01100 add, 00100 sub, 00101/01101 and, 00110/01110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol (shift count B[4:0]), 01111 signed mul (64-bit), 10000 signed div (Zlo=quotient, Zhi=remainder; divide by 0 -> Z=0), 10001 neg B, 10010 not B; others Z=0. Non-mul results: Zhi=0.
REQ-018 Zin loads 64-bit Z at edge; PC, IR, MAR, Y, HI, LO load bus on their enables.
REQ-019 MDRin: loads Mem_to_datapath_out when Mem_Read=1, else bus.
REQ-020 Memory 512x32, combinational read: Mem_to_datapath_out = mem[addr] when enable&read, else 0; addr = overide_address if mem_overide else MAR[8:0].
REQ-021 Write at rising edge when Mem_enable512x32&Mem_Write (data=MDR) or Mem_enable512x32&mem_overide (data=overide_data_in); override has priority.
REQ-022 memory_done = Mem_enable512x32 (single-cycle access).
REQ-023 CONin: con_ff_bit <= f(bus, IR[20:19]): 00 bus==0, 01 bus!=0, 10 bus[31]==0, 11 bus[31]==1.
REQ-024 inport_data_ready loads inport register; outport_in loads outport from bus.

Reset
REQ-025 clear=0 SHALL immediately zero PC, IR, MAR, MDR, Y, Z, HI, LO, R0-R15, CON, inport, outport; memory contents unchanged; reset mid-operation aborts any write in that cycle.

Structure
REQ-026 Shared package: widths, opcode constants, C2 condition codes.
REQ-027 One sub-module system_alu (combinational ALU, REQ-017); rest in system.

Verification
REQ-028 Override load mem[0]=0x0A800000, mem[1]=0x9A800001, mem[3]=0x9A880001, mem[4]=0x9A900001, mem[5]=0x9A980001 -> readback matches.
REQ-029 Fetch from PC=0: PCout+IncPC+MARin+Zin; Zlo_out+PCin+MDRin+Mem_Read+enable; MDRout+IRin -> MAR=0, PC=1, IR=0x0A800000.
REQ-030 ldi r5,0: Grb+BAout+Yin; Cout+Zin opcode 00011; Zlo_out+Gra+Rin -> R5=0.
REQ-031 brzr r5,1 at addr1: fetch -> PC=2; Gra+Rout+CONin -> con_ff_bit=1; PCout+Yin; Cout+Zin add -> Zlo=3; Zlo_out+PCin -> PC=3.
REQ-032 With R5=0: brnz -> con 0 (PC stays 4); brpl -> con 1 (PC 4->6 taken); brmi -> con 0.
REQ-033 Y=7, bus=-3, opcode 01111 -> Zhi=0xFFFFFFFF, Zlo=0xFFFFFFEB; clear low mid-sequence -> PC=0, con_ff_bit=0.
